// File: rtl/sfifo_rr_arbiter.sv
// Round-robin arbiter that merges COUNT valid/ready requesters onto one registered output stream.
// With PACKET=1 a requester keeps the grant until a beat carrying last=1 is accepted.
module sfifo_rr_arbiter #(
  parameter int WIDTH  = 32,
  parameter int COUNT  = 4,
  parameter int PACKET = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COUNT-1:0]         in_valid,
  output logic [COUNT-1:0]         in_ready,
  input  logic [COUNT*WIDTH-1:0]   in_data,
  input  logic [COUNT-1:0]         in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [COUNT-1:0]         grant,
  output logic                     busy
);

  localparam int IDX_W = $clog2(COUNT);
  localparam logic [IDX_W:0]   COUNT_W  = (IDX_W+1)'(COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT-1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              accept;
  logic              xfer;
  logic              release_beat;
  logic              any_valid;
  logic              owner_valid;
  logic              owner_last;
  logic [WIDTH-1:0]  owner_data;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  next_ptr;

  logic [WIDTH-1:0]  data_arr [COUNT];
  logic [IDX_W-1:0]  cand_idx [COUNT];

  // cand_idx[k] is the requester examined k-th when searching from ptr_q
  for (genvar gi = 0; gi < COUNT; gi++) begin : g_req
    logic [IDX_W:0] sum;
    assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
    assign sum          = {1'b0, ptr_q} + (IDX_W+1)'(gi);
    assign cand_idx[gi] = (sum >= COUNT_W) ? IDX_W'(sum - COUNT_W) : sum[IDX_W-1:0];
    assign grant[gi]    = (state_q == LOCK) && (owner_q == IDX_W'(gi));
    assign in_ready[gi] = grant[gi] && accept && reset;
  end

  assign accept       = !out_valid_q || out_ready;
  assign owner_valid  = in_valid[owner_q];
  assign owner_last   = in_last[owner_q];
  assign owner_data   = data_arr[owner_q];
  assign xfer         = (state_q == LOCK) && owner_valid && accept;
  assign release_beat = xfer && ((PACKET == 0) || owner_last);
  assign next_ptr     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign any_valid    = |in_valid;

  // Walk the search order backwards so the earliest candidate wins.
  always_comb begin
    pick_idx = ptr_q;
    for (int k = COUNT-1; k >= 0; k--) begin
      if (in_valid[cand_idx[k]]) begin
        pick_idx = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (release_beat) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = owner_data;
      out_last_d  = owner_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == LOCK);

endmodule
